regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the RV32I core family. It generalises the single-write, two-read file to NREAD read ports and NWRITE write ports. It adds a per-register busy scoreboard for multi-cycle/pipelined writeback and a post-reset clearing sequencer. It sits between decode (read/issue) and writeback.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers; power of two, >= 2; register 0 hard-wired to zero
NREAD, 2, number of read ports
NWRITE, 2, number of write ports; higher port index has priority
(localparam IDXW = $clog2(NREGS))

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
ready  output  1  high when clearing sequence done and file is usable
wb_en  input  NWRITE  per-port write enable
wb_index  input  NWRITE*IDXW  per-port destination index, port p at [p*IDXW +: IDXW]
wb_data  input  NWRITE*XLEN  per-port write data, port p at [p*XLEN +: XLEN]
rs_index  input  NREAD*IDXW  per-port read index
rs_data  output  NREAD*XLEN  per-port read data
rs_busy  output  NREAD  per-port: addressed register has an outstanding producer
issue_en  input  1  mark issue_rd as pending a writeback
issue_rd  input  IDXW  destination being issued

Behaviour:
- Reset: synchronous, active-high, sampled at rising edge of clk. While rst is high: state<=CLEAR, clear pointer<=0, all busy bits<=0, ready=0.
- FSM states CLEAR, RUN.
  - CLEAR: each cycle writes 0 to reg[ptr] and increments ptr. When ptr==NREGS-1 that write happens and state->RUN.
  - ready is 0 for exactly NREGS cycles after the first edge with rst low, then 1.
  - RUN: normal operation. Stays in RUN until rst.
- rst asserted mid-CLEAR or mid-RUN restarts CLEAR from ptr=0. Busy bits are cleared; register contents are not guaranteed until CLEAR completes.
- In CLEAR: wb_en and issue_en are ignored, rs_data reads 0, rs_busy reads 0.
- Reads are combinational: rs_data[p] = reg[rs_index[p]]. Index 0 always reads 0.
- Writes commit on the rising edge when wb_en[p]=1 and wb_index[p]!=0. Writes to index 0 are discarded.
- Same-edge write conflict (two ports, same index): the highest-numbered enabled port's data is stored.
- Scoreboard busy[NREGS]:
  - set at edge when issue_en=1 and issue_rd!=0;
  - cleared at edge when any wb_en[p] targets that index.
  - Set and clear on the same index at the same edge: set wins, because the new producer supersedes.
  - busy[0] is always 0.
- rs_busy[p] = busy[rs_index[p]] (registered state, combinational lookup).
- Latency: write visible on reads the cycle after commit (see optional feature). Busy set/clear is visible the cycle after the edge.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If wb_en[q]=1, wb_index[q]==rs_index[p], and the index is !=0 in RUN, then rs_data[p]=wb_data[q] in the same cycle. The highest such q wins, and rs_busy[p] is forced 0 for that port.
- Undefined: reads return the pre-edge stored value. rs_busy reflects stored busy only.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> ready=0 for 32 cycles, then 1. All rs_data=0 for every index.
- Basic write/read: wb_en[0]=1, idx 5, data 0xDEADBEEF -> next cycle rs_index[1]=5 gives 0xDEADBEEF. Write 0x1234 to idx 0 -> reads 0.
- Port conflict: same edge, port0 writes idx 7=0x11 and port1 writes idx 7=0x22 -> idx 7 reads 0x22.
- Scoreboard: issue_rd=9 -> rs_busy=1 on idx 9 next cycle. wb to 9 -> busy 0 next cycle. Simultaneous issue_rd=9 and wb to 9 -> busy remains 1.
- Reset mid-operation: write idx 3=0xA5A5A5A5, assert rst during RUN, release -> ready low 32 cycles, then idx 3 reads 0 and all busy=0. Writes during CLEAR do not persist.
- Bypass: same cycle wb idx 4=0x55 and rs_index=4 -> with REGFILE_BYPASS_EN rs_data=0x55 that cycle. Without it, rs_data shows the old value, then 0x55 the next cycle.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port RV32I register file with busy scoreboard and post-reset clearing sequencer.
// Optional REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on every read port.
module regfile_mp_rport #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NWRITE = 2,
  parameter int IDXW   = 5
) (
  input  logic                         run,
  input  logic [IDXW-1:0]              index,
  input  logic [NREGS-1:0][XLEN-1:0]   regs,
  input  logic [NREGS-1:0]             busy,
  input  logic [NWRITE-1:0]            wb_en,
  input  logic [NWRITE*IDXW-1:0]       wb_index,
  input  logic [NWRITE*XLEN-1:0]       wb_data,
  output logic [XLEN-1:0]              data,
  output logic                         bsy
);
`ifndef REGFILE_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_index, wb_data};
`endif

  always_comb begin
    data = '0;
    bsy  = 1'b0;
    if (run && index != '0) begin
      data = regs[index];
      bsy  = busy[index];
`ifdef REGFILE_BYPASS_EN
      // ascending scan so the highest matching write port wins
      for (int q = 0; q < NWRITE; q++) begin
        if (wb_en[q] && wb_index[q*IDXW +: IDXW] == index) begin
          data = wb_data[q*XLEN +: XLEN];
          bsy  = 1'b0;
        end
      end
`endif
    end
  end
endmodule

module regfile_mp #(
  parameter int  XLEN   = 32,
  parameter int  NREGS  = 32,
  parameter int  NREAD  = 2,
  parameter int  NWRITE = 2,
  localparam int IDXW   = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NWRITE-1:0]        wb_en,
  input  logic [NWRITE*IDXW-1:0]   wb_index,
  input  logic [NWRITE*XLEN-1:0]   wb_data,
  input  logic [NREAD*IDXW-1:0]    rs_index,
  output logic [NREAD*XLEN-1:0]    rs_data,
  output logic [NREAD-1:0]         rs_busy,
  input  logic                     issue_en,
  input  logic [IDXW-1:0]          issue_rd
);
  typedef enum logic {CLEAR, RUN} state_t;

  state_t                     state, state_nxt;
  logic [IDXW-1:0]            ptr;
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy;

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && ptr == IDXW'(NREGS-1)) state_nxt = RUN;
  end

  always_comb ready = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst)                 ptr <= '0;
    else if (state == CLEAR) ptr <= ptr + 1'b1;
  end

  // Contents are not reset; the clearing sequencer zeroes them instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) regs[ptr] <= '0;
      else begin
        for (int p = 0; p < NWRITE; p++)
          if (wb_en[p] && wb_index[p*IDXW +: IDXW] != '0)
            regs[wb_index[p*IDXW +: IDXW]] <= wb_data[p*XLEN +: XLEN];
      end
    end
  end

  // Issue is applied after writeback clears so a new producer supersedes.
  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else if (state == RUN) begin
      for (int p = 0; p < NWRITE; p++)
        if (wb_en[p]) busy[wb_index[p*IDXW +: IDXW]] <= 1'b0;
      if (issue_en && issue_rd != '0) busy[issue_rd] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    regfile_mp_rport #(.XLEN(XLEN), .NREGS(NREGS), .NWRITE(NWRITE), .IDXW(IDXW)) u_rport (
      .run      (ready),
      .index    (rs_index[p*IDXW +: IDXW]),
      .regs     (regs),
      .busy     (busy),
      .wb_en    (wb_en),
      .wb_index (wb_index),
      .wb_data  (wb_data),
      .data     (rs_data[p*XLEN +: XLEN]),
      .bsy      (rs_busy[p])
    );
  end
endmodule
